// File: rtl/fpu_scheduler.sv
// Round-robin scheduler sharing one two-phase CFpu adder among N_REQ requesters.
// Operands are issued aligned to the FPU CALCULO phase; results return over a response handshake.
module fpu_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                  m_clk,
    input  logic                  m_reset,
    input  logic [N_REQ-1:0]      m_reqValid,
    output logic [N_REQ-1:0]      m_reqReady,
    input  logic [N_REQ*32-1:0]   m_reqOpA,
    input  logic [N_REQ*32-1:0]   m_reqOpB,
    output logic [31:0]           m_fpuOpA,
    output logic [31:0]           m_fpuOpB,
    input  logic [31:0]           m_fpuData,
    input  logic [1:0]            m_fpuStatus,
    output logic                  m_rspValid,
    input  logic                  m_rspReady,
    output logic [ID_W-1:0]       m_rspId,
    output logic [31:0]           m_rspData,
    output logic [1:0]            m_rspStatus,
    output logic                  m_busy,
    output logic [15:0]           m_opCount
);
    typedef enum logic [1:0] {EXACT, INEXACT, OVERFLOW, UNDERFLOW} status_e;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_RESP} state_e;

    state_e          state_q;
    logic            phase_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     fpu_a_q;
    logic [31:0]     fpu_b_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [31:0]     rsp_data_q;
    status_e         rsp_status_q;
    logic [15:0]     op_count_q;

    logic            grant_d;
    logic [ID_W-1:0] win_d;
    logic [ID_W-1:0] ptr_d;
    logic [31:0]     op_a_d;
    logic [31:0]     op_b_d;
    int unsigned     idx;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        grant_d = 1'b0;
        win_d   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!grant_d && m_reqValid[ID_W'(idx)]) begin
                grant_d = 1'b1;
                win_d   = ID_W'(idx);
            end
        end
        ptr_d  = ID_W'((32'(win_d) + 1) % N_REQ);
        op_a_d = '0;
        op_b_d = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win_d == ID_W'(k)) begin
                op_a_d = m_reqOpA[k*32 +: 32];
                op_b_d = m_reqOpB[k*32 +: 32];
            end
        end
    end

    always_comb begin
        m_reqReady = '0;
        if (m_reset && state_q == S_IDLE && grant_d)
            m_reqReady[win_d] = 1'b1;
    end

    always_ff @(posedge m_clk or negedge m_reset) begin
        if (!m_reset) begin
            state_q      <= S_IDLE;
            phase_q      <= 1'b0;
            ptr_q        <= '0;
            id_q         <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= EXACT;
            op_count_q   <= '0;
        end else begin
            phase_q <= ~phase_q;
            case (state_q)
                S_IDLE: begin
                    if (grant_d) begin
                        fpu_a_q <= op_a_d;
                        fpu_b_q <= op_b_d;
                        id_q    <= win_d;
                        ptr_q   <= ptr_d;
                        state_q <= S_ISSUE;
                    end
                end
                // phase 0 means the FPU samples operands on this edge
                S_ISSUE: if (!phase_q) state_q <= S_WAIT;
                S_WAIT:  state_q <= S_CAPT;
                S_CAPT: begin
                    rsp_data_q   <= m_fpuData;
                    rsp_status_q <= status_e'(m_fpuStatus);
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (m_rspReady) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_fpuOpA    = fpu_a_q;
    assign m_fpuOpB    = fpu_b_q;
    assign m_rspValid  = rsp_valid_q;
    assign m_rspId     = rsp_id_q;
    assign m_rspData   = rsp_data_q;
    assign m_rspStatus = rsp_status_q;
    assign m_busy      = (state_q != S_IDLE);
    assign m_opCount   = op_count_q;

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed bench for fpu_scheduler with a behavioural two-phase CFpu adder model.
module tb_fpu_scheduler;
    localparam int N = 4;
    localparam logic [1:0] ST_EXACT = 2'd0, ST_INEXACT = 2'd1, ST_OVF = 2'd2;

    logic            m_clk = 1'b0;
    logic            m_reset = 1'b1;
    logic [N-1:0]    m_reqValid = '0;
    logic [N-1:0]    m_reqReady;
    logic [N*32-1:0] m_reqOpA = '0;
    logic [N*32-1:0] m_reqOpB = '0;
    logic [31:0]     m_fpuOpA, m_fpuOpB;
    logic [31:0]     m_fpuData;
    logic [1:0]      m_fpuStatus;
    logic            m_rspValid;
    logic            m_rspReady = 1'b1;
    logic [1:0]      m_rspId;
    logic [31:0]     m_rspData;
    logic [1:0]      m_rspStatus;
    logic            m_busy;
    logic [15:0]     m_opCount;

    int ncmp = 0;
    int nfail = 0;
    int exp_cnt = 0;
    logic ph_post = 1'b0;

    logic        fph;
    logic [31:0] fa, fb;

    always #5 m_clk = ~m_clk;

    fpu_scheduler #(.N_REQ(N)) dut (
        .m_clk(m_clk), .m_reset(m_reset),
        .m_reqValid(m_reqValid), .m_reqReady(m_reqReady),
        .m_reqOpA(m_reqOpA), .m_reqOpB(m_reqOpB),
        .m_fpuOpA(m_fpuOpA), .m_fpuOpB(m_fpuOpB),
        .m_fpuData(m_fpuData), .m_fpuStatus(m_fpuStatus),
        .m_rspValid(m_rspValid), .m_rspReady(m_rspReady),
        .m_rspId(m_rspId), .m_rspData(m_rspData), .m_rspStatus(m_rspStatus),
        .m_busy(m_busy), .m_opCount(m_opCount)
    );

    // Positive normal operands only; truncating add returning {status, result}.
    function automatic logic [33:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [10:0] e;
        logic [44:0] mx, my;
        logic [45:0] s;
        int unsigned d;
        logic lost;
        if (a[30:20] >= b[30:20]) begin x = a; y = b; end
        else begin x = b; y = a; end
        e  = x[30:20];
        d  = 32'(x[30:20] - y[30:20]);
        mx = {1'b1, x[19:0], 24'd0};
        my = {1'b1, y[19:0], 24'd0};
        lost = 1'b0;
        if (d > 44) begin
            lost = 1'b1;
            my = '0;
        end else begin
            for (int unsigned i = 0; i < d; i++) lost |= my[i];
            my = my >> d;
        end
        s = {1'b0, mx} + {1'b0, my};
        if (s[45]) begin
            lost |= s[0];
            s = s >> 1;
            e = e + 11'd1;
        end
        lost |= (s[23:0] != 24'd0);
        if (e == 11'h7FF) return {ST_OVF, 32'h7FF00000};
        return {(lost ? ST_INEXACT : ST_EXACT), 1'b0, e, s[43:24]};
    endfunction

    // CFpu model: samples operands when phase is 0, presents the sum after the next edge.
    always @(posedge m_clk or negedge m_reset) begin
        if (!m_reset) begin
            fph <= 1'b0; fa <= '0; fb <= '0;
            m_fpuData <= '0; m_fpuStatus <= ST_EXACT;
        end else begin
            fph <= ~fph;
            if (!fph) begin
                fa <= m_fpuOpA;
                fb <= m_fpuOpB;
            end else begin
                {m_fpuStatus, m_fpuData} <= fadd(fa, fb);
            end
        end
    end

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [1:0]  st;
        int          ph;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_reqReady", 32'(m_reqReady), 0);
        chk("rst_fpuOpA", m_fpuOpA, 0);
        chk("rst_fpuOpB", m_fpuOpB, 0);
        chk("rst_rspData", m_rspData, 0);
        chk("rst_rspId", 32'(m_rspId), 0);
        chk("rst_rspStatus", 32'(m_rspStatus), 32'(ST_EXACT));
        chk("rst_rspValid", 32'(m_rspValid), 0);
        chk("rst_busy", 32'(m_busy), 0);
        chk("rst_opCount", 32'(m_opCount), 0);
    endtask

    task automatic do_reset();
        m_reqValid = '1;
        #2 m_reset = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(posedge m_clk);
        m_reqValid = '0;
        @(negedge m_clk) m_reset = 1'b1;
        exp_cnt = 0;
        @(posedge m_clk); #1;
    endtask

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
        m_reqOpA[id*32 +: 32] = a;
        m_reqOpB[id*32 +: 32] = b;
    endtask

    task automatic wait_grant(output int g);
        int n = 0;
        #1;
        while (m_reqReady == '0 && n < 40) begin
            @(posedge m_clk); #1;
            n++;
        end
        chk("grant_seen", 32'(m_reqReady != '0), 1);
        chk("grant_onehot", 32'($countones(m_reqReady)), 1);
        g = -1;
        for (int i = 0; i < N; i++) if (m_reqReady[i]) g = i;
        @(posedge m_clk); #1;
        ph_post = fph;
        chk("ready_one_cycle", 32'(m_reqReady), 0);
        chk("busy_after_accept", 32'(m_busy), 1);
    endtask

    task automatic wait_rsp(input int id, input logic [31:0] res, input logic [1:0] st);
        int cyc = 0;
        while (!m_rspValid && cyc < 10) begin
            @(posedge m_clk); #1;
            cyc++;
        end
        chk("rsp_valid", 32'(m_rspValid), 1);
        chk("latency", cyc, ph_post ? 4 : 3);
        chk("rsp_id", 32'(m_rspId), id);
        chk("rsp_data", m_rspData, res);
        chk("rsp_status", 32'(m_rspStatus), 32'(st));
        if (m_rspReady) begin
            @(posedge m_clk); #1;
            exp_cnt++;
            chk("rsp_clear", 32'(m_rspValid), 0);
            chk("op_count", 32'(m_opCount), exp_cnt);
        end
    endtask

    task automatic run_op(input vec_t v);
        int g;
        if (v.ph >= 0) while (int'(fph) == v.ph) begin @(posedge m_clk); #1; end
        set_ops(v.id, v.a, v.b);
        m_reqValid[v.id] = 1'b1;
        wait_grant(g);
        m_reqValid[v.id] = 1'b0;
        chk("grant_id", g, v.id);
        chk("fpu_opA", m_fpuOpA, v.a);
        chk("fpu_opB", m_fpuOpB, v.b);
        wait_rsp(v.id, v.res, v.st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        int ord[5];
        logic [31:0] rr_res[4];

        vt[0] = '{id: 0, a: 32'h3FF00000, b: 32'h3FF00000, res: 32'h40000000, st: ST_EXACT,   ph: 0};
        vt[1] = '{id: 1, a: 32'h40000000, b: 32'h3FF00000, res: 32'h40080000, st: ST_EXACT,   ph: 1};
        vt[2] = '{id: 2, a: 32'h40080000, b: 32'h3FF00000, res: 32'h40100000, st: ST_EXACT,   ph: 0};
        vt[3] = '{id: 3, a: 32'h3FF00000, b: 32'h3EA00000, res: 32'h3FF00000, st: ST_INEXACT, ph: 1};
        vt[4] = '{id: 0, a: 32'h7FEFFFFF, b: 32'h7FEFFFFF, res: 32'h7FF00000, st: ST_OVF,     ph: 0};
        vt[5] = '{id: 1, a: 32'h3FF80000, b: 32'h3FF80000, res: 32'h40080000, st: ST_EXACT,   ph: 1};

        do_reset();
        for (int i = 0; i < 6; i++) run_op(vt[i]);

        // Round-robin from reset with every requester continuously valid.
        do_reset();
        ord = '{0, 1, 2, 3, 0};
        rr_res = '{32'h40000000, 32'h40080000, 32'h40100000, 32'h40040000};
        set_ops(0, 32'h3FF00000, 32'h3FF00000);
        set_ops(1, 32'h3FF00000, 32'h40000000);
        set_ops(2, 32'h3FF00000, 32'h40080000);
        set_ops(3, 32'h3FF00000, 32'h3FF80000);
        m_reqValid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            if (k == 4) m_reqValid = '0;
            chk("rr_order", g, ord[k]);
            wait_rsp(ord[k], rr_res[ord[k]], ST_EXACT);
        end

        // Pointer wrap: after serving 2, requester 3 must win over 0.
        run_op('{id: 2, a: 32'h3FF00000, b: 32'h3FF00000, res: 32'h40000000, st: ST_EXACT, ph: -1});
        set_ops(0, 32'h40000000, 32'h3FF00000);
        set_ops(3, 32'h40000000, 32'h40000000);
        m_reqValid[0] = 1'b1;
        m_reqValid[3] = 1'b1;
        wait_grant(g);
        m_reqValid[3] = 1'b0;
        chk("wrap_first", g, 3);
        wait_rsp(3, 32'h40100000, ST_EXACT);
        wait_grant(g);
        m_reqValid[0] = 1'b0;
        chk("wrap_second", g, 0);
        wait_rsp(0, 32'h40080000, ST_EXACT);

        // Backpressure with requester 1 waiting.
        m_rspReady = 1'b0;
        set_ops(0, 32'h40000000, 32'h40000000);
        m_reqValid[0] = 1'b1;
        wait_grant(g);
        m_reqValid[0] = 1'b0;
        chk("bp_grant", g, 0);
        set_ops(1, 32'h3FF00000, 32'h3FF00000);
        m_reqValid[1] = 1'b1;
        wait_rsp(0, 32'h40100000, ST_EXACT);
        for (int c = 0; c < 10; c++) begin
            @(posedge m_clk); #1;
            chk("bp_valid", 32'(m_rspValid), 1);
            chk("bp_data", m_rspData, 32'h40100000);
            chk("bp_id", 32'(m_rspId), 0);
            chk("bp_ready_low", 32'(m_reqReady), 0);
        end
        m_rspReady = 1'b1;
        @(posedge m_clk); #1;
        exp_cnt++;
        chk("bp_rsp_clear", 32'(m_rspValid), 0);
        chk("bp_op_count", 32'(m_opCount), exp_cnt);
        chk("bp_next_ready", 32'(m_reqReady), 32'h2);
        wait_grant(g);
        m_reqValid[1] = 1'b0;
        chk("bp_grant_1", g, 1);
        wait_rsp(1, 32'h40000000, ST_EXACT);

        // Reset asserted while the operation is in WAIT.
        while (fph == 1'b0) begin @(posedge m_clk); #1; end
        set_ops(3, 32'h3FF00000, 32'h3FF00000);
        m_reqValid[3] = 1'b1;
        wait_grant(g);
        m_reqValid[3] = 1'b0;
        @(posedge m_clk); #1;
        chk("mid_busy", 32'(m_busy), 1);
        m_reqValid = '1;
        #2 m_reset = 1'b0;
        #1 chk_reset_vals();
        exp_cnt = 0;
        repeat (2) @(posedge m_clk);
        #1 chk("rst_hold_valid", 32'(m_rspValid), 0);
        m_reqValid = '0;
        @(negedge m_clk) m_reset = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin
                @(posedge m_clk); #1;
                if (m_rspValid || m_busy) seen++;
            end
            chk("no_rsp_after_reset", seen, 0);
        end
        run_op('{id: 1, a: 32'h40080000, b: 32'h3FF00000, res: 32'h40100000, st: ST_EXACT, ph: -1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
